// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding IMEM requests,
// buffers one response and feeds the IF/OF latch, squashing wrong-path work on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h6800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        isBranchTaken,
    input  logic [31:0] branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q, tag_d;
    logic        discard_q, discard_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic        fill;
    logic [31:0] target;

    // A full buffer only blocks a new request when it cannot drain this cycle.
    always_comb begin
        imem_req  = rst_n && (state_q == S_FETCH) && (!buf_valid_q || !stall);
        imem_addr = pc_q;
        accept    = imem_req && imem_ready;
        target    = {branch[31:2], 2'b00};
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tag_d       = tag_q;
        discard_d   = discard_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        fill        = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (accept) begin
                    state_d   = S_WAIT;
                    tag_d     = pc_q;
                    pc_d      = pc_q + 32'd4;
                    discard_d = isBranchTaken;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d   = S_FETCH;
                    discard_d = 1'b0;
                    fill      = !discard_q && !isBranchTaken;
                end else if (isBranchTaken) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (isBranchTaken) begin
            pc_d        = target;
            buf_valid_d = 1'b0;
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
        end else if (!stall) begin
            if (buf_valid_q) begin
                pc_out_d    = buf_pc_q;
                instr_d     = buf_instr_q;
                valid_d     = 1'b1;
                buf_valid_d = 1'b0;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end

        // A response landing while the buffer drains refills it in the same cycle.
        if (fill) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = tag_q;
            buf_instr_d = imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            pc_out_q    <= 32'h0000_0000;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            buf_valid_q <= buf_valid_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
        end
    end

    // Payload registers are qualified by state/buf_valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q       <= tag_d;
        buf_pc_q    <= buf_pc_d;
        buf_instr_q <= buf_instr_d;
    end

    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

endmodule
